// File: rtl/phy_sym_pkg.sv
// Symbol constants and shared types for the PHY TX symbol scheduler.
package phy_sym_pkg;

    localparam logic [7:0] SYM_COM    = 8'hBC;  // K28.5
    localparam logic [7:0] SYM_SKP    = 8'h1C;  // K28.0
    localparam logic [7:0] SYM_IDL    = 8'h7C;  // K28.3
    localparam logic [7:0] SYM_PAD    = 8'hF7;  // K23.7
    localparam logic [7:0] SYM_TS1_ID = 8'h4A;  // D10.2
    localparam logic [7:0] SYM_TS2_ID = 8'h45;  // D5.2
    localparam logic [7:0] SYM_LIDL   = 8'h00;

    localparam logic [3:0] TS_LAST   = 4'd15;
    localparam logic [3:0] EIOS_LAST = 4'd3;

    typedef enum logic [2:0] {
        OFF,
        DATA,
        SKP,
        TS,
        EIOS,
        EIDLE
    } tx_state_t;

    typedef enum logic [1:0] {
        OS_SKP,
        OS_TS1,
        OS_TS2,
        OS_EIOS
    } os_kind_t;

    function automatic os_kind_t ts_kind(input logic sel);
        return sel ? OS_TS2 : OS_TS1;
    endfunction

endpackage

// File: rtl/phy_os_gen.sv
// Ordered-set symbol lookup: (kind, index) -> symbol, K flag and last marker.
module phy_os_gen
    import phy_sym_pkg::*;
#(
    parameter int         SKP_NUM = 3,
    parameter logic [7:0] N_FTS   = 8'hFF,
    parameter logic [7:0] RATE_ID = 8'h02
) (
    input  os_kind_t   os_kind,
    input  logic [3:0] index,
    output logic       k,
    output logic [7:0] data,
    output logic       last
);

    localparam logic [3:0] SKP_LAST = 4'(SKP_NUM);

    always_comb begin
        k    = 1'b0;
        data = SYM_LIDL;
        last = 1'b0;
        unique case (os_kind)
            OS_SKP: begin
                k    = 1'b1;
                data = (index == 4'd0) ? SYM_COM : SYM_SKP;
                last = (index == SKP_LAST);
            end
            OS_EIOS: begin
                k    = 1'b1;
                data = (index == 4'd0) ? SYM_COM : SYM_IDL;
                last = (index == EIOS_LAST);
            end
            OS_TS1, OS_TS2: begin
                last = (index == TS_LAST);
                case (index)
                    4'd0: begin
                        k    = 1'b1;
                        data = SYM_COM;
                    end
                    4'd1, 4'd2: begin
                        k    = 1'b1;
                        data = SYM_PAD;
                    end
                    4'd3:    data = N_FTS;
                    4'd4:    data = RATE_ID;
                    4'd5:    data = SYM_LIDL;
                    default: begin
                        data = (os_kind == OS_TS2) ? SYM_TS2_ID
                                                   : SYM_TS1_ID;
                    end
                endcase
            end
            default: begin
                k    = 1'b0;
                data = SYM_LIDL;
                last = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/phy_tx_sched.sv
// PHY TX symbol scheduler: shares the encoder slot between link data,
// TS1/TS2, EIOS and periodic SKP sets; all encoder-facing outputs registered.
module phy_tx_sched
    import phy_sym_pkg::*;
#(
    parameter int         SKP_INTERVAL = 1180,
    parameter int         SKP_NUM      = 3,
    parameter logic [7:0] N_FTS        = 8'hFF,
    parameter logic [7:0] RATE_ID      = 8'h02
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tx_en,
    input  logic [7:0] in_data,
    input  logic       in_datak,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       ts_req,
    input  logic       ts_sel,
    output logic       ts_done,
    input  logic       eidle_req,
    output logic       eidle_act,
    output logic [7:0] txdata,
    output logic       txdatak,
    output logic       en_n
);

    localparam int            CW      = $clog2(SKP_INTERVAL);
    localparam logic [CW-1:0] CNT_TOP = CW'(SKP_INTERVAL - 1);

    tx_state_t     state, state_nx;
    tx_state_t     pick;
    logic [3:0]    idx, idx_nx;
    logic [CW-1:0] skp_cnt, skp_cnt_nx;
    logic          skp_pend, skp_pend_nx;
    logic          ts_sel_q, ts_sel_nx;

    os_kind_t      os_kind;
    logic          os_k;
    logic [7:0]    os_data;
    logic          os_last;

    logic          emit;
    logic          expire;
    logic          pend_now;
    logic          boundary;

    logic [7:0]    txdata_nx;
    logic          txdatak_nx;
    logic          en_n_nx;
    logic          in_ready_nx;
    logic          ts_done_nx;
    logic          eidle_act_nx;

    always_comb begin
        unique case (state)
            TS:      os_kind = ts_kind(ts_sel_q);
            EIOS:    os_kind = OS_EIOS;
            default: os_kind = OS_SKP;
        endcase
    end

    phy_os_gen #(
        .SKP_NUM (SKP_NUM),
        .N_FTS   (N_FTS),
        .RATE_ID (RATE_ID)
    ) u_os_gen (
        .os_kind (os_kind),
        .index   (idx),
        .k       (os_k),
        .data    (os_data),
        .last    (os_last)
    );

    // A symbol boundary is any DATA cycle or the last symbol of SKP/TS;
    // EIOS always hands over to EIDLE instead.
    always_comb begin
        emit     = tx_en && (state inside {DATA, SKP, TS, EIOS});
        expire   = emit && (skp_cnt == CNT_TOP);
        pend_now = skp_pend || expire;
        boundary = (state == DATA)
                || ((state inside {SKP, TS}) && os_last);
        if (pend_now)       pick = SKP;
        else if (eidle_req) pick = EIOS;
        else if (ts_req)    pick = TS;
        else                pick = DATA;
    end

    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        skp_cnt_nx   = skp_cnt;
        skp_pend_nx  = skp_pend;
        ts_sel_nx    = ts_sel_q;
        txdata_nx    = SYM_LIDL;
        txdatak_nx   = 1'b0;
        en_n_nx      = 1'b1;
        ts_done_nx   = 1'b0;
        eidle_act_nx = 1'b0;

        if (!tx_en) begin
            state_nx    = OFF;
            idx_nx      = '0;
            skp_cnt_nx  = '0;
            skp_pend_nx = 1'b0;
        end else begin
            unique case (state)
                OFF: begin
                    state_nx   = DATA;
                    skp_cnt_nx = '0;
                end
                EIDLE: begin
                    eidle_act_nx = 1'b1;
                    skp_cnt_nx   = '0;
                    if (!eidle_req) state_nx = DATA;
                end
                DATA: begin
                    en_n_nx = 1'b0;
                    if (in_valid && in_ready) begin
                        txdata_nx  = in_data;
                        txdatak_nx = in_datak;
                    end
                end
                default: begin
                    en_n_nx    = 1'b0;
                    txdata_nx  = os_data;
                    txdatak_nx = os_k;
                    idx_nx     = idx + 4'd1;
                    if (os_last) begin
                        idx_nx     = '0;
                        ts_done_nx = (state == TS);
                        if (state == EIOS) state_nx = EIDLE;
                    end
                end
            endcase

            if (emit) skp_cnt_nx = expire ? '0 : skp_cnt + 1'b1;

            if (boundary) begin
                state_nx = pick;
                idx_nx   = '0;
                if (pick == TS) ts_sel_nx = ts_sel;
            end

            // An expiry that coincides with SKP entry is consumed by it.
            skp_pend_nx = (boundary && pick == SKP) ? 1'b0 : pend_now;
        end

        in_ready_nx = (state_nx == DATA);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= OFF;
            idx       <= '0;
            skp_cnt   <= '0;
            skp_pend  <= 1'b0;
            ts_sel_q  <= 1'b0;
            txdata    <= '0;
            txdatak   <= 1'b0;
            en_n      <= 1'b1;
            in_ready  <= 1'b0;
            ts_done   <= 1'b0;
            eidle_act <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            skp_cnt   <= skp_cnt_nx;
            skp_pend  <= skp_pend_nx;
            ts_sel_q  <= ts_sel_nx;
            txdata    <= txdata_nx;
            txdatak   <= txdatak_nx;
            en_n      <= en_n_nx;
            in_ready  <= in_ready_nx;
            ts_done   <= ts_done_nx;
            eidle_act <= eidle_act_nx;
        end
    end

endmodule

// File: tb/tb_phy_tx_sched.sv
// Bench for phy_tx_sched: directed vectors, corner sequences and a
// queue-based reference model checked every cycle under random stimulus.
module tb_phy_tx_sched;

    localparam int         SKP_INTERVAL = 1180;
    localparam int         SKP_NUM      = 3;
    localparam logic [7:0] N_FTS        = 8'hFF;
    localparam logic [7:0] RATE_ID      = 8'h02;

    logic       clk;
    logic       reset_n;
    logic       tx_en;
    logic [7:0] in_data;
    logic       in_datak;
    logic       in_valid;
    logic       in_ready;
    logic       ts_req;
    logic       ts_sel;
    logic       ts_done;
    logic       eidle_req;
    logic       eidle_act;
    logic [7:0] txdata;
    logic       txdatak;
    logic       en_n;

    int n_chk = 0;
    int n_fail = 0;

    phy_tx_sched #(
        .SKP_INTERVAL (SKP_INTERVAL),
        .SKP_NUM      (SKP_NUM),
        .N_FTS        (N_FTS),
        .RATE_ID      (RATE_ID)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tx_en     (tx_en),
        .in_data   (in_data),
        .in_datak  (in_datak),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ts_req    (ts_req),
        .ts_sel    (ts_sel),
        .ts_done   (ts_done),
        .eidle_req (eidle_req),
        .eidle_act (eidle_act),
        .txdata    (txdata),
        .txdatak   (txdatak),
        .en_n      (en_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       k;
        logic [7:0] d;
        logic       ts_last;
        logic       eios_last;
    } sym_t;

    sym_t sq[$];
    int   m_mode = 0;  // 0 off, 1 on, 2 electrical idle
    int   m_cnt = 0;
    bit   m_pend = 0;
    bit   m_live = 0;
    logic [7:0] e_data = 8'h00;
    logic e_k = 1'b0, e_en_n = 1'b1, e_rdy = 1'b0;
    logic e_done = 1'b0, e_eact = 1'b0;

    function automatic sym_t ms(input logic k, input logic [7:0] d,
                                input logic tl, input logic el);
        sym_t s;
        s.k = k;
        s.d = d;
        s.ts_last = tl;
        s.eios_last = el;
        return s;
    endfunction

    task automatic push_set(input int kind, input logic sel);
        if (kind == 0) begin
            sq.push_back(ms(1'b1, 8'hBC, 1'b0, 1'b0));
            for (int i = 0; i < SKP_NUM; i++)
                sq.push_back(ms(1'b1, 8'h1C, 1'b0, 1'b0));
        end else if (kind == 1) begin
            sq.push_back(ms(1'b1, 8'hBC, 1'b0, 1'b0));
            for (int i = 0; i < 3; i++)
                sq.push_back(ms(1'b1, 8'h7C, 1'b0, i == 2));
        end else begin
            sq.push_back(ms(1'b1, 8'hBC, 1'b0, 1'b0));
            sq.push_back(ms(1'b1, 8'hF7, 1'b0, 1'b0));
            sq.push_back(ms(1'b1, 8'hF7, 1'b0, 1'b0));
            sq.push_back(ms(1'b0, N_FTS, 1'b0, 1'b0));
            sq.push_back(ms(1'b0, RATE_ID, 1'b0, 1'b0));
            sq.push_back(ms(1'b0, 8'h00, 1'b0, 1'b0));
            for (int i = 0; i < 10; i++)
                sq.push_back(ms(1'b0, sel ? 8'h45 : 8'h4A, i == 9, 1'b0));
        end
    endtask

    task automatic model_step();
        sym_t s;
        bit   was_eios;
        e_data = 8'h00;
        e_k    = 1'b0;
        e_en_n = 1'b1;
        e_done = 1'b0;
        e_eact = 1'b0;
        if (!reset_n || !tx_en) begin
            m_mode = 0;
            sq.delete();
            m_cnt  = 0;
            m_pend = 0;
            e_rdy  = 1'b0;
        end else if (m_mode == 0) begin
            m_mode = 1;
            e_rdy  = 1'b1;
        end else if (m_mode == 2) begin
            e_eact = 1'b1;
            m_cnt  = 0;
            e_rdy  = !eidle_req;
            if (!eidle_req) m_mode = 1;
        end else begin
            was_eios = 0;
            e_en_n = 1'b0;
            if (sq.size() == 0) begin
                if (in_valid) begin
                    e_data = in_data;
                    e_k    = in_datak;
                end
            end else begin
                s = sq.pop_front();
                e_data   = s.d;
                e_k      = s.k;
                e_done   = s.ts_last;
                was_eios = s.eios_last;
            end
            if (m_cnt == SKP_INTERVAL - 1) begin
                m_cnt  = 0;
                m_pend = 1;
            end else begin
                m_cnt++;
            end
            if (sq.size() != 0) begin
                e_rdy = 1'b0;
            end else if (was_eios) begin
                m_mode = 2;
                e_rdy  = 1'b0;
            end else begin
                if (m_pend) begin
                    push_set(0, 1'b0);
                    m_pend = 0;
                end else if (eidle_req) begin
                    push_set(1, 1'b0);
                end else if (ts_req) begin
                    push_set(2, ts_sel);
                end
                e_rdy = (sq.size() == 0);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        m_live = 1;
    end

    initial forever begin
        @(negedge clk);
        if (m_live) begin
            chk("model_cmp",
                32'({txdata, txdatak, en_n, in_ready, ts_done, eidle_act}),
                32'({e_data, e_k, e_en_n, e_rdy, e_done, e_eact}));
        end
    end

    // ---------------- directed stimulus ----------------
    typedef struct {
        logic       ts_req;
        logic       ts_sel;
        logic [7:0] data;
        logic       k;
        logic       rdy;
        logic       done;
    } vec_t;

    function automatic vec_t mkv(input logic r, input logic s,
                                 input logic [7:0] d, input logic k,
                                 input logic rdy, input logic done);
        vec_t v;
        v.ts_req = r;
        v.ts_sel = s;
        v.data   = d;
        v.k      = k;
        v.rdy    = rdy;
        v.done   = done;
        return v;
    endfunction

    vec_t        tbl[18];
    logic [8:0]  outs[$];
    logic [8:0]  exp_s[$];
    logic [10:0] eexp[6];

    task automatic grab();
        if (!en_n && !(txdata == 8'h00 && !txdatak))
            outs.push_back({txdatak, txdata});
    endtask

    initial begin
        int   cnt_idle, cur, lowcnt, held, pulses, kcnt, ehold, thold;
        bit   found, acc;

        tbl[0]  = mkv(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mkv(1'b0, 1'b1, 8'hBC, 1'b1, 1'b0, 1'b0);
        tbl[2]  = mkv(1'b0, 1'b1, 8'hF7, 1'b1, 1'b0, 1'b0);
        tbl[3]  = mkv(1'b0, 1'b1, 8'hF7, 1'b1, 1'b0, 1'b0);
        tbl[4]  = mkv(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        tbl[5]  = mkv(1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
        tbl[6]  = mkv(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 7; i < 16; i++)
            tbl[i] = mkv(1'b0, 1'b1, 8'h45, 1'b0, 1'b0, 1'b0);
        tbl[16] = mkv(1'b0, 1'b1, 8'h45, 1'b0, 1'b1, 1'b1);
        tbl[17] = mkv(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);

        eexp[0] = {1'b0, 8'h00, 1'b0, 1'b0};
        eexp[1] = {1'b1, 8'hBC, 1'b0, 1'b0};
        eexp[2] = {1'b1, 8'h7C, 1'b0, 1'b0};
        eexp[3] = {1'b1, 8'h7C, 1'b0, 1'b0};
        eexp[4] = {1'b1, 8'h7C, 1'b0, 1'b0};
        eexp[5] = {1'b0, 8'h00, 1'b1, 1'b1};

        reset_n = 1'b0; tx_en = 1'b0; in_data = 8'h00; in_datak = 1'b0;
        in_valid = 1'b0; ts_req = 1'b0; ts_sel = 1'b0; eidle_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_vals",
            32'({txdata, txdatak, en_n, in_ready, ts_done, eidle_act}),
            32'({8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));

        // Idle link: first SKP after exactly SKP_INTERVAL symbols.
        reset_n = 1'b1;
        tx_en   = 1'b1;
        cnt_idle = 0;
        found    = 0;
        for (int i = 0; i < 1300 && !found; i++) begin
            @(negedge clk);
            if (!en_n && txdatak && txdata == 8'hBC) found = 1;
            else if (!en_n) cnt_idle++;
        end
        chk("first_skp_found", 32'(found), 32'd1);
        chk("idle_before_skp", 32'(cnt_idle), 32'(SKP_INTERVAL));
        for (int i = 0; i < SKP_NUM; i++) begin
            @(negedge clk);
            chk($sformatf("skp_sym%0d", i), 32'({txdatak, txdata}),
                32'({1'b1, 8'h1C}));
        end
        repeat (4) @(negedge clk);

        // One TS2 set driven from the vector table.
        for (int i = 0; i < 18; i++) begin
            ts_req = tbl[i].ts_req;
            ts_sel = tbl[i].ts_sel;
            @(negedge clk);
            chk($sformatf("ts_vec%0d", i),
                32'({txdata, txdatak, en_n, in_ready, ts_done}),
                32'({tbl[i].data, tbl[i].k, 1'b0, tbl[i].rdy, tbl[i].done}));
        end

        // EIOS wins over TS; no TS while eidle_req stays high.
        ts_req = 1'b1; ts_sel = 1'b0; eidle_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("eios_seq%0d", i),
                32'({txdatak, txdata, en_n, eidle_act}), 32'(eexp[i]));
        end
        held = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (en_n && eidle_act) held++;
        end
        chk("eidle_hold", 32'(held), 32'd20);
        ts_req = 1'b0; eidle_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("eidle_exit", 32'({en_n, eidle_act}), 32'd0);
        repeat (3) @(negedge clk);

        // tx_en dropped at TS symbol 7.
        ts_req = 1'b1; ts_sel = 1'b0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (!en_n && txdatak && txdata == 8'hBC) found = 1;
        end
        chk("abort_ts_start", 32'(found), 32'd1);
        repeat (7) @(negedge clk);
        chk("abort_ts_sym7", 32'({txdatak, txdata}), 32'({1'b0, 8'h4A}));
        tx_en = 1'b0; ts_req = 1'b0;
        @(negedge clk);
        chk("abort_off", 32'({en_n, txdatak, txdata}), 32'({1'b1, 9'h000}));
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ts_done) pulses++;
        end
        chk("abort_no_done", 32'(pulses), 32'd0);

        // Re-enable: counter restarted, data 01..20 straddles the SKP set.
        tx_en = 1'b1;
        repeat (SKP_INTERVAL - 4) @(negedge clk);
        cur = 1; lowcnt = 0;
        outs.delete();
        for (int c = 0; c < 80 && cur <= 32; c++) begin
            in_valid = 1'b1;
            in_data  = 8'(cur);
            in_datak = 1'b0;
            acc = in_ready;
            if (!in_ready) lowcnt++;
            @(negedge clk);
            grab();
            if (acc) cur++;
        end
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            grab();
        end
        exp_s.delete();
        for (int i = 1; i <= 5; i++) exp_s.push_back({1'b0, 8'(i)});
        exp_s.push_back({1'b1, 8'hBC});
        for (int i = 0; i < SKP_NUM; i++) exp_s.push_back({1'b1, 8'h1C});
        for (int i = 6; i <= 32; i++) exp_s.push_back({1'b0, 8'(i)});
        chk("stream_len", 32'(outs.size()), 32'(exp_s.size()));
        for (int i = 0; i < exp_s.size() && i < outs.size(); i++)
            chk($sformatf("stream%0d", i), 32'(outs[i]), 32'(exp_s[i]));
        chk("stream_rdy_low", 32'(lowcnt), 32'(SKP_NUM + 1));

        // Reset pulse on the COM of the next SKP set.
        found = 0;
        for (int i = 0; i < 1300 && !found; i++) begin
            @(negedge clk);
            if (!en_n && txdatak && txdata == 8'hBC) found = 1;
        end
        chk("rst_skp_found", 32'(found), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_skp",
            32'({txdata, txdatak, en_n, in_ready, ts_done, eidle_act}),
            32'({8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
        reset_n = 1'b1;
        kcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (txdatak) kcnt++;
        end
        chk("rst_no_resume", 32'(kcnt), 32'd0);

        // Random traffic against the model.
        ehold = 0; thold = 0;
        for (int c = 0; c < 4000; c++) begin
            reset_n  = ($urandom_range(0, 599) != 0);
            tx_en    = ($urandom_range(0, 399) != 0);
            in_valid = $urandom_range(0, 1) != 0;
            in_data  = 8'($urandom_range(0, 255));
            in_datak = ($urandom_range(0, 7) == 0);
            if (ehold > 0) ehold--;
            else if ($urandom_range(0, 299) == 0) ehold = $urandom_range(1, 30);
            if (thold > 0) thold--;
            else if ($urandom_range(0, 24) == 0) thold = $urandom_range(1, 20);
            eidle_req = (ehold > 0);
            ts_req    = (thold > 0);
            ts_sel    = $urandom_range(0, 1) != 0;
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
